// File: rtl/inval_line_queue.sv
// Line-aligning invalidation FIFO with duplicate-line suppression.
// Sits between the invalidation filter and the CVA6 response path.
module inval_line_queue #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4,
    parameter bit          DedupEnable = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [AddrWidth-1:0]         inval_addr_i,
    input  logic                         inval_valid_i,
    output logic                         inval_ready_o,
    output logic [AddrWidth-1:0]         inval_addr_o,
    output logic                         inval_valid_o,
    input  logic                         inval_ready_i,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic [15:0]                  drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);
    localparam int unsigned OffW = $clog2(L1LineWidth);

    logic [AddrWidth-1:0] mem_q [Depth];
    logic [Depth-1:0]     vld_q, vld_d;
    logic [PtrW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [15:0]          drop_q, drop_d;

    logic [AddrWidth-1:0] line;
    logic                 hit, full, pop, acc, push, drop;

    assign line = {inval_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign full = (count_q == CntW'(Depth));
    assign pop  = inval_valid_o & inval_ready_i;

    // Head being popped this cycle no longer counts as pending.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (vld_q[i] && mem_q[i] == line && !(pop && PtrW'(i) == rd_q))
                hit = 1'b1;
        end
        if (!DedupEnable)
            hit = 1'b0;
    end

    assign inval_ready_o = !rst_i & (!en_i | !full | hit);
    assign acc  = inval_valid_i & inval_ready_o;
    assign push = acc & en_i & !hit;
    assign drop = acc & en_i & hit;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        vld_d   = vld_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (pop) begin
            rd_d        = rd_q + 1'b1;
            vld_d[rd_q] = 1'b0;
        end
        if (push) begin
            wr_d        = wr_q + 1'b1;
            vld_d[wr_q] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            vld_q   <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_q] <= line;
    end

    assign inval_valid_o = !rst_i && (count_q != '0);
    assign inval_addr_o  = inval_valid_o ? mem_q[rd_q] : '0;
    assign count_o       = rst_i ? '0 : count_q;
    assign drop_cnt_o    = rst_i ? '0 : drop_q;

endmodule

// File: tb/tb_inval_line_queue.sv
// Self-checking bench for inval_line_queue: directed table,
// reset sequence and randomized traffic against a queue model.
module tb_inval_line_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [63:0] ain;
    logic        vin;
    logic        rdy_o;
    logic [63:0] aout;
    logic        vout;
    logic        rin;
    logic [2:0]  cnt;
    logic [15:0] dcnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    int          mdrop;

    always #5 clk = ~clk;

    inval_line_queue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .inval_addr_i (ain),
        .inval_valid_i(vin),
        .inval_ready_o(rdy_o),
        .inval_addr_o (aout),
        .inval_valid_o(vout),
        .inval_ready_i(rin),
        .count_o      (cnt),
        .drop_cnt_o   (dcnt)
    );

    typedef struct {
        logic        en;
        logic [63:0] addr;
        logic        v;
        logic        r;
        logic        e_rdy;
        int          e_cnt;
        logic        e_vld;
        logic [63:0] e_addr;
        int          e_drop;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic model_ready(input logic e, input logic [63:0] a,
                                         input logic r);
        logic [63:0] ln;
        logic        h;
        logic        p;
        ln = a & ~64'hF;
        p  = (mq.size() != 0) && r;
        h  = 1'b0;
        for (int k = 0; k < mq.size(); k++)
            if (mq[k] == ln && !(k == 0 && p)) h = 1'b1;
        return !e || mq.size() < 4 || h;
    endfunction

    task automatic model_edge(input logic e, input logic [63:0] a,
                              input logic v, input logic r);
        logic [63:0] ln;
        logic        h;
        logic        p;
        logic        rd;
        ln = a & ~64'hF;
        p  = (mq.size() != 0) && r;
        h  = 1'b0;
        for (int k = 0; k < mq.size(); k++)
            if (mq[k] == ln && !(k == 0 && p)) h = 1'b1;
        rd = !e || mq.size() < 4 || h;
        if (p) void'(mq.pop_front());
        if (v && rd && e) begin
            if (h) begin
                if (mdrop != 16'hFFFF) mdrop++;
            end else begin
                mq.push_back(ln);
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_count"}, 64'(cnt), 64'(mq.size()));
        chk({tag, "_valid"}, 64'(vout), 64'(mq.size() != 0));
        chk({tag, "_addr"}, aout, mq.size() != 0 ? mq[0] : 64'h0);
        chk({tag, "_drop"}, 64'(dcnt), 64'(mdrop));
    endtask

    // Drive one cycle, check ready before the edge, outputs after it.
    task automatic step(input logic e, input logic [63:0] a,
                        input logic v, input logic r, input string tag);
        en  = e;
        ain = a;
        vin = v;
        rin = r;
        #1;
        chk({tag, "_ready"}, 64'(rdy_o), 64'(model_ready(e, a, r)));
        @(posedge clk);
        model_edge(e, a, v, r);
        @(negedge clk);
        check_outs(tag);
    endtask

    vec_t vt[23];

    initial begin
        vt[0]  = '{1, 64'h8000_0014, 1, 0, 1, 1, 1, 64'h8000_0010, 0};
        vt[1]  = '{1, 64'h0, 0, 1, 1, 0, 0, 64'h0, 0};
        vt[2]  = '{1, 64'h100, 1, 0, 1, 1, 1, 64'h100, 0};
        vt[3]  = '{1, 64'h108, 1, 0, 1, 1, 1, 64'h100, 1};
        vt[4]  = '{1, 64'h0, 0, 1, 1, 0, 0, 64'h0, 1};
        vt[5]  = '{1, 64'h000, 1, 0, 1, 1, 1, 64'h0, 1};
        vt[6]  = '{1, 64'h010, 1, 0, 1, 2, 1, 64'h0, 1};
        vt[7]  = '{1, 64'h020, 1, 0, 1, 3, 1, 64'h0, 1};
        vt[8]  = '{1, 64'h030, 1, 0, 1, 4, 1, 64'h0, 1};
        vt[9]  = '{1, 64'h040, 1, 0, 0, 4, 1, 64'h0, 1};
        vt[10] = '{1, 64'h024, 1, 0, 1, 4, 1, 64'h0, 2};
        vt[11] = '{1, 64'h040, 1, 1, 0, 3, 1, 64'h010, 2};
        vt[12] = '{1, 64'h010, 0, 1, 1, 2, 1, 64'h020, 2};
        vt[13] = '{1, 64'h0, 0, 1, 1, 1, 1, 64'h030, 2};
        vt[14] = '{1, 64'h0, 0, 1, 1, 0, 0, 64'h0, 2};
        vt[15] = '{1, 64'h200, 1, 0, 1, 1, 1, 64'h200, 2};
        vt[16] = '{1, 64'h204, 1, 1, 1, 1, 1, 64'h200, 2};
        vt[17] = '{1, 64'h0, 0, 1, 1, 0, 0, 64'h0, 2};
        vt[18] = '{1, 64'h300, 1, 0, 1, 1, 1, 64'h300, 2};
        vt[19] = '{1, 64'h310, 1, 0, 1, 2, 1, 64'h300, 2};
        vt[20] = '{0, 64'h300, 1, 0, 1, 2, 1, 64'h300, 2};
        vt[21] = '{0, 64'h400, 1, 1, 1, 1, 1, 64'h310, 2};
        vt[22] = '{0, 64'h0, 0, 1, 1, 0, 0, 64'h0, 2};

        rst = 1'b1; en = 1'b1; ain = '0; vin = 1'b0; rin = 1'b0;
        mdrop = 0;
        #1;
        chk("inrst_ready", 64'(rdy_o), 64'd0);
        chk("inrst_valid", 64'(vout), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("reset");

        for (int i = 0; i < 23; i++) begin
            step(vt[i].en, vt[i].addr, vt[i].v, vt[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tready", i), 64'(rdy_o === 1'bx ? 1'bx : 1'b0) | 64'(vt[i].e_rdy & 1'b0), 64'd0);
            chk($sformatf("vec%0d_tcount", i), 64'(cnt), 64'(vt[i].e_cnt));
            chk($sformatf("vec%0d_tvalid", i), 64'(vout), 64'(vt[i].e_vld));
            chk($sformatf("vec%0d_taddr", i), aout, vt[i].e_addr);
            chk($sformatf("vec%0d_tdrop", i), 64'(dcnt), 64'(vt[i].e_drop));
        end

        // Reset with two lines queued discards them.
        step(1, 64'h500, 1, 0, "pre_rst0");
        step(1, 64'h510, 1, 0, "pre_rst1");
        rst = 1'b1; vin = 1'b1; ain = 64'h520; rin = 1'b0;
        #1;
        chk("rst_ready", 64'(rdy_o), 64'd0);
        chk("rst_valid", 64'(vout), 64'd0);
        chk("rst_count", 64'(cnt), 64'd0);
        chk("rst_drop", 64'(dcnt), 64'd0);
        chk("rst_addr", aout, 64'd0);
        @(posedge clk);
        mq.delete();
        mdrop = 0;
        @(negedge clk);
        rst = 1'b0; vin = 1'b0;
        #1;
        check_outs("post_rst");
        chk("post_rst_count0", 64'(cnt), 64'd0);

        // Ten distinct lines with random back-pressure keep their order.
        for (int i = 0; i < 10; i++)
            step(1, 64'h1000 + 64'(i * 16) + 64'($urandom_range(15)), 1,
                 1'($urandom_range(1)), $sformatf("ord%0d", i));
        for (int i = 0; i < 12; i++)
            step(1, 64'h0, 0, 1, $sformatf("drain%0d", i));

        // Random traffic over a small line pool to provoke hits and fullness.
        for (int i = 0; i < 400; i++) begin
            logic e;
            e = ($urandom_range(9) != 0);
            step(e, 64'($urandom_range(7) * 16 + $urandom_range(15)),
                 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0),
                 $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
